// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stage-register controls exchanged between the datapath and pipe_ctrl.
// master = datapath/cache side, slave = pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             d_req;
  logic             halt_i;
  logic             pc_redirect;
  logic             idex_ren;
  logic [REG_W-1:0] idex_wsel;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             ifid_use_rt;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halt_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, d_req, halt_i, pc_redirect, idex_ren, idex_wsel,
           ifid_rs, ifid_rt, ifid_use_rt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt_o,
           stall_cnt, bubble_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, d_req, halt_i, pc_redirect, idex_ren, idex_wsel,
           ifid_rs, ifid_rt, ifid_use_rt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt_o,
           stall_cnt, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: enables/flushes are combinational, halt is sticky.
// Optional perf counters under PIPE_PERF_CNT_EN (undefined: counter outputs tied to 0).
module pipe_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic        CLK,
  input  logic        nRST,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t           st;
  logic             dhit_seen;
  logic             halt_q;
  logic [REG_W-1:0] wsel;
  logic             lu;
  logic             d_done;
  logic             adv;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush;

  assign wsel   = bus.idex_wsel;
  assign lu     = bus.idex_ren && (wsel != '0) &&
                  ((wsel == bus.ifid_rs) || (bus.ifid_use_rt && (wsel == bus.ifid_rt)));
  assign d_done = !bus.d_req || bus.dhit || dhit_seen;
  assign adv    = (st == RUN) && bus.ihit && d_done;

  // Priority: halt > redirect > load-use > plain advance; nRST gating keeps outputs 0 in reset.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (nRST && adv) begin
      if (bus.halt_i) begin
        memwb_en = 1'b1;
      end else if (bus.pc_redirect) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
      end else if (lu) begin
        {idex_en, exmem_en, memwb_en} = 3'b111;
        idex_flush                    = 1'b1;
      end else begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st        <= RUN;
      dhit_seen <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      if (adv)
        dhit_seen <= 1'b0;
      else if ((st == RUN) && bus.dhit)
        dhit_seen <= 1'b1;
      if (adv && bus.halt_i) begin
        st     <= HALTED;
        halt_q <= 1'b1;
      end
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.halt_o      = halt_q && nRST;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] stall_q, bubble_q, flush_q;
  logic             stall_ev, bubble_ev, flush_ev;

  assign stall_ev  = (st == RUN) && !adv;
  assign bubble_ev = adv && !bus.halt_i && !bus.pc_redirect && lu;
  assign flush_ev  = adv && !bus.halt_i && bus.pc_redirect;

  // Saturating: hold at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (stall_ev && (stall_q != '1))
        stall_q <= stall_q + CNT_ONE;
      if (bubble_ev && (bubble_q != '1))
        bubble_q <= bubble_q + CNT_ONE;
      if (flush_ev && (flush_q != '1))
        flush_q <= flush_q + CNT_ONE;
    end
  end

  assign bus.stall_cnt  = stall_q;
  assign bus.bubble_cnt = bubble_q;
  assign bus.flush_cnt  = flush_q;
`else
  assign bus.stall_cnt  = {CNT_W{1'b0}};
  assign bus.bubble_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall, load-use, redirect, halt, reset and counter cases.
// Outputs are driven/sampled around the falling edge, away from the rising active edge.
module tb_pipe_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  logic CLK;
  logic nRST;
  int   n_chk;
  int   n_err;

  pipe_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, exmem_flush}
  logic [7:0] ev;
  assign ev = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
               bus.ifid_flush, bus.idex_flush, bus.exmem_flush};

  localparam logic [7:0] EV_NONE   = 8'b00000_000;
  localparam logic [7:0] EV_ALL    = 8'b11111_000;
  localparam logic [7:0] EV_BUBBLE = 8'b00111_010;
  localparam logic [7:0] EV_FLUSH  = 8'b11111_111;
  localparam logic [7:0] EV_HALT   = 8'b00001_000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change right after the falling edge; outputs are read 2 time units later.
  task automatic step(input logic ihit, input logic dhit, input logic d_req,
                      input logic halt, input logic redir, input logic ren,
                      input logic [4:0] wsel, input logic [4:0] rs,
                      input logic [4:0] rt, input logic use_rt);
    @(negedge CLK);
    bus.ihit        = ihit;
    bus.dhit        = dhit;
    bus.d_req       = d_req;
    bus.halt_i      = halt;
    bus.pc_redirect = redir;
    bus.idex_ren    = ren;
    bus.idex_wsel   = wsel;
    bus.ifid_rs     = rs;
    bus.ifid_rt     = rt;
    bus.ifid_use_rt = use_rt;
    #2;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    nRST = 1'b0;
    #2;
  endtask

  logic [31:0] exp_stall, exp_bubble, exp_flush;

  initial begin
    n_chk = 0;
    n_err = 0;
    nRST  = 1'b1;
`ifdef PIPE_PERF_CNT_EN
    exp_stall = 32'd5; exp_bubble = 32'd1; exp_flush = 32'd1;
`else
    exp_stall = 32'd0; exp_bubble = 32'd0; exp_flush = 32'd0;
`endif
    // Reset asserted with inputs that would otherwise advance.
    #1 nRST = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_ev", {24'd0, ev}, {24'd0, EV_NONE});
    check("rst_halt", {31'd0, bus.halt_o}, 32'd0);
    check("rst_stall_cnt", bus.stall_cnt, 32'd0);
    #1 nRST = 1'b1;

    // 1: free-running advance.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check($sformatf("run_ev%0d", i), {24'd0, ev}, {24'd0, EV_ALL});
      check($sformatf("run_halt%0d", i), {31'd0, bus.halt_o}, 32'd0);
    end

    // 2: D-miss, dhit at cyc3 held until ihit at cyc5.
    for (int c = 0; c < 5; c++) begin
      step(0, (c == 3), 1, 0, 0, 0, 0, 0, 0, 0);
      check($sformatf("dwait_ev%0d", c), {24'd0, ev}, {24'd0, EV_NONE});
      if (c == 4) check("dhit_seen_c4", {31'd0, dut.dhit_seen}, 32'd1);
    end
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("dwait_ev5", {24'd0, ev}, {24'd0, EV_ALL});
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("dhit_seen_c6", {31'd0, dut.dhit_seen}, 32'd0);

    // 3: load-use on rs, then same with wsel=0.
    step(1, 0, 0, 0, 0, 1, 5, 5, 0, 0);
    check("lu_rs_ev", {24'd0, ev}, {24'd0, EV_BUBBLE});
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    check("lu_r0_ev", {24'd0, ev}, {24'd0, EV_ALL});

    // 4: redirect outranks load-use.
    step(1, 0, 0, 0, 1, 1, 5, 5, 0, 0);
    check("redir_lu_ev", {24'd0, ev}, {24'd0, EV_FLUSH});

    // 6: counters after scenarios 2-4.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("stall_cnt", bus.stall_cnt, exp_stall);
    check("bubble_cnt", bus.bubble_cnt, exp_bubble);
    check("flush_cnt", bus.flush_cnt, exp_flush);

    // Load-use through rt, and rt ignored when not used.
    step(1, 0, 0, 0, 0, 1, 7, 3, 7, 1);
    check("lu_rt_ev", {24'd0, ev}, {24'd0, EV_BUBBLE});
    step(1, 0, 0, 0, 0, 1, 7, 3, 7, 0);
    check("lu_rt_unused_ev", {24'd0, ev}, {24'd0, EV_ALL});

    // dhit and ihit together: advance without latching dhit_seen.
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("dhit_ihit_ev", {24'd0, ev}, {24'd0, EV_ALL});
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("dhit_ihit_seen", {31'd0, dut.dhit_seen}, 32'd0);

    // ihit while D access pending: no advance.
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("ihit_dpend_ev", {24'd0, ev}, {24'd0, EV_NONE});

    // Reset mid-wait drops a captured dhit.
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("midwait_seen_set", {31'd0, dut.dhit_seen}, 32'd1);
    pulse_reset();
    check("midwait_seen_rst", {31'd0, dut.dhit_seen}, 32'd0);
    #1 nRST = 1'b1;
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("midwait_no_carry", {24'd0, ev}, {24'd0, EV_NONE});

    // 5: halt outranks redirect and load-use, then sticks until reset.
    step(1, 0, 0, 1, 1, 1, 5, 5, 0, 0);
    check("halt_ev", {24'd0, ev}, {24'd0, EV_HALT});
    check("halt_o_pre", {31'd0, bus.halt_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check($sformatf("halted_ev%0d", i), {24'd0, ev}, {24'd0, EV_NONE});
      check($sformatf("halted_o%0d", i), {31'd0, bus.halt_o}, 32'd1);
    end
    pulse_reset();
    check("halt_rst_o", {31'd0, bus.halt_o}, 32'd0);
    check("halt_rst_cnt", bus.flush_cnt, 32'd0);
    #1 nRST = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("after_rst_ev", {24'd0, ev}, {24'd0, EV_ALL});
    check("after_rst_halt", {31'd0, bus.halt_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
